// File: rtl/serial_pattern_gen.sv
`timescale 1ns/1ps
// serial_pattern_gen
// Parallel-load, MSB-first serial bit-stream transmitter. A frame of 1..WIDTH
// bits is accepted over a valid/ready handshake and shifted out one bit per
// clock on `out`, framed by first/last strobes.
//
// Optional feature macro: SERIAL_PARITY_EN
//   defined   : one extra even-parity bit follows the data bits (state PAR)
//   undefined : last marks the final data bit; no parity logic
//
// State table:
//   IDLE  | no frame in flight, outputs quiet, ready for a load
//   SHIFT | a data bit of the current frame is on `out`
//   PAR   | the parity bit is on `out` (SERIAL_PARITY_EN only)
//
// Ports:
//   Clk        in   system clock, rising edge
//   Clr        in   asynchronous active-low reset
//   load_valid in   load request
//   load_ready out  frame can be accepted this cycle
//   load_data  in   frame bits, left-aligned, MSB sent first
//   load_len   in   frame length; 0 or >WIDTH means WIDTH
//   out        out  serial data bit
//   out_valid  out  `out` carries a frame bit
//   first      out  first bit of a frame
//   last       out  final bit of a frame (parity bit when enabled)
//   busy       out  frame in progress
module serial_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             out,
    output logic             out_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
`ifdef SERIAL_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [LEN_W-1:0]   len_eff;
    logic               accept;

    assign len_eff    = (load_len == '0 || load_len > WIDTH_L) ? WIDTH_L : load_len;
    // last_q is only ever set on the final bit of a frame, so it doubles as
    // the "can chain the next frame" condition.
    assign load_ready = Clr && (state_q == IDLE || last_q);
    assign accept     = load_valid && load_ready;

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_d       = par_q;
`endif

        if (accept) begin
            // The MSB goes straight to the output flop; the shift register
            // holds the bits still to come and the counter how many remain.
            state_d     = SHIFT;
            shreg_d     = load_data << 1;
            cnt_d       = len_eff - ONE_L;
            out_d       = load_data[WIDTH-1];
            out_valid_d = 1'b1;
            first_d     = 1'b1;
`ifdef SERIAL_PARITY_EN
            par_d       = load_data[WIDTH-1];
`else
            last_d      = (len_eff == ONE_L);
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef SERIAL_PARITY_EN
                        state_d     = PAR;
                        out_d       = par_q;
                        out_valid_d = 1'b1;
                        last_d      = 1'b1;
`else
                        state_d     = IDLE;
`endif
                    end else begin
                        shreg_d     = shreg_q << 1;
                        cnt_d       = cnt_q - ONE_L;
                        out_d       = shreg_q[WIDTH-1];
                        out_valid_d = 1'b1;
`ifdef SERIAL_PARITY_EN
                        par_d       = par_q ^ shreg_q[WIDTH-1];
`else
                        last_d      = (cnt_q == ONE_L);
`endif
                    end
                end
`ifdef SERIAL_PARITY_EN
                PAR: begin
                    state_d = IDLE;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
`ifdef SERIAL_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
`timescale 1ns/1ps
module tb_serial_pattern_gen;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             Clk = 1'b0;
    logic             Clr = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic             out, out_valid, first, last, busy;

    serial_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .Clk(Clk), .Clr(Clr),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len),
        .out(out), .out_valid(out_valid), .first(first), .last(last),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is just the top len_eff bits of data, MSB first,
    // optionally followed by their XOR.
    task automatic push_model(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        int n;
        logic p;
        exp_bit_t e;
        n = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.b = d[WIDTH-1-i];
            e.f = (i == 0);
`ifdef SERIAL_PARITY_EN
            e.l = 1'b0;
`else
            e.l = (i == n - 1);
`endif
            p = p ^ e.b;
            exp_q.push_back(e);
        end
`ifdef SERIAL_PARITY_EN
        e.b = p; e.f = 1'b0; e.l = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    // Monitor: one expected entry per out_valid cycle; an empty queue means
    // the block must be idle and ready.
    initial begin
        exp_bit_t e;
        forever begin
            @(negedge Clk);
            if (mon_en && Clr) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_valid", 32'(out_valid), 32'd1);
                    chk("out", 32'(out), 32'(e.b));
                    chk("first", 32'(first), 32'(e.f));
                    chk("last", 32'(last), 32'(e.l));
                    chk("busy", 32'(busy), 32'd1);
                    chk("load_ready", 32'(load_ready), 32'(e.l));
                end else begin
                    chk("idle_out_valid", 32'(out_valid), 32'd0);
                    chk("idle_out", 32'(out), 32'd0);
                    chk("idle_first_last", 32'({first, last}), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                    chk("idle_load_ready", 32'(load_ready), 32'd1);
                end
            end
        end
    end

    // Holds load_valid until accepted; with scramble set the word changes
    // every refused cycle, and only the word present at accept is expected.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                              input bit scramble);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge Clk);
            load_valid = 1'b1;
            if (scramble && n > 0) begin
                load_data = WIDTH'($urandom);
                load_len  = LEN_W'($urandom);
            end else begin
                load_data = d;
                load_len  = l;
            end
            #3;
            if (load_ready) begin
                push_model(load_data, load_len);
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    chk("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        load_valid = 1'b0;
        load_data  = WIDTH'($urandom);
        load_len   = LEN_W'($urandom);
    endtask

    initial begin
        int w;
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_first_last", 32'({first, last}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        load_valid = 1'b1;
        #1;
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        #4;
        Clr = 1'b1;
        mon_en = 1'b1;
        idle_cycle();

        send_frame(16'h5B6D, 5'd0, 1'b0);
        idle_cycle();
        repeat (17) idle_cycle();
        send_frame(16'hA000, 5'd3, 1'b0);
        repeat (5) idle_cycle();
        send_frame(16'h8000, 5'd1, 1'b0);
        repeat (3) idle_cycle();
        send_frame(16'hF000, 5'd4, 1'b0);
        send_frame(16'h0000, 5'd4, 1'b0);
        repeat (10) idle_cycle();
        send_frame(16'hB000, 5'd4, 1'b0);
        repeat (7) idle_cycle();
        send_frame(16'h1234, 5'd20, 1'b0);
        repeat (20) idle_cycle();

        // Asynchronous reset mid-frame, at bit 5 of 16.
        send_frame(16'hFFFF, 5'd0, 1'b0);
        idle_cycle();
        repeat (4) @(negedge Clk);
        #1;
        Clr = 1'b0;
        #1;
        chk("clr_out", 32'(out), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_load_ready", 32'(load_ready), 32'd0);
        #1;
        Clr = 1'b1;
        exp_q.delete();
        #1;
        chk("clr_release_ready", 32'(load_ready), 32'd1);
        repeat (20) idle_cycle();

        for (int k = 0; k < 80; k++) begin
            w = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) w = 0;
            for (int g = 0; g < w; g++) idle_cycle();
            send_frame(WIDTH'($urandom), LEN_W'($urandom), bit'($urandom_range(0, 1)));
        end
        idle_cycle();

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
